// File: rtl/dco_freq_meter.sv
// Frequency meter for the DCO square wave: counts synchronized rising edges over a
// programmable gate window and tracks the latest high/low half-period lengths.
module dco_freq_meter #(
    parameter int unsigned CNT_W  = 12,
    parameter int unsigned GATE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dco_in,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              start,
    output logic              busy,
    output logic              valid,
    input  logic              ready,
    output logic [CNT_W-1:0]  cnt_out,
    output logic              ovf,
    output logic              nosig,
    output logic [7:0]        hi_len,
    output logic [7:0]        lo_len
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_HOLD
    } state_e;

    state_e            state_q;
    logic              s1_q, s2_q, s3_q;
    logic [GATE_W-1:0] gate_q;
    logic [GATE_W-1:0] gcnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              ovf_q;
    logic              nosig_q;
    logic              busy_q;
    logic              valid_q;
    logic [7:0]        run_q;
    logic [7:0]        run_d;
    logic [7:0]        hi_q;
    logic [7:0]        lo_q;
    logic              seen_rise_q;
    logic              seen_fall_q;

    logic rise;
    logic fall;
    logic start_ok;
    logic enter_arm;
    logic gate_last;
    logic tracking;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= dco_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_comb begin
        rise      = s2_q & ~s3_q;
        fall      = ~s2_q & s3_q;
        start_ok  = start && (gate_len != '0);
        enter_arm = (state_q == ST_IDLE) && start_ok;
        gate_last = (gcnt_q == GATE_W'(1));
        tracking  = (state_q == ST_ARM) || (state_q == ST_MEASURE);
        cnt_d     = cnt_q + CNT_W'(1);
        run_d     = (&run_q) ? run_q : run_q + 8'd1;
    end

    // gcnt_q doubles as the ARM timeout and the MEASURE gate counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gate_q  <= '0;
            gcnt_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            nosig_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        gate_q  <= gate_len;
                        gcnt_q  <= gate_len;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        nosig_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (rise) begin
                        gcnt_q  <= gate_q;
                        state_q <= ST_MEASURE;
                    end else if (gate_last) begin
                        nosig_q <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end else begin
                        gcnt_q <= gcnt_q - GATE_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        if (&cnt_q) begin
                            ovf_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    if (gate_last) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end else begin
                        gcnt_q <= gcnt_q - GATE_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A half-period is captured only when it started on an edge seen in this measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            seen_rise_q <= 1'b0;
            seen_fall_q <= 1'b0;
        end else if (enter_arm) begin
            run_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            seen_rise_q <= 1'b0;
            seen_fall_q <= 1'b0;
        end else if (tracking) begin
            if (rise || fall) begin
                run_q <= '0;
            end else begin
                run_q <= run_d;
            end
            if (fall) begin
                if (seen_rise_q) begin
                    hi_q <= run_d;
                end
                seen_fall_q <= 1'b1;
            end
            if (rise) begin
                if (seen_fall_q) begin
                    lo_q <= run_d;
                end
                seen_rise_q <= 1'b1;
            end
        end
    end

    assign busy    = busy_q;
    assign valid   = valid_q;
    assign cnt_out = cnt_q;
    assign ovf     = ovf_q;
    assign nosig   = nosig_q;
    assign hi_len  = hi_q;
    assign lo_len  = lo_q;

endmodule

// File: tb/tb_dco_freq_meter.sv
// Scoreboard bench for dco_freq_meter: a 12-bit and a 4-bit count instance share stimulus.
module tb_dco_freq_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dco_in = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic [15:0] gate_len = '0;

    logic        busy, valid, ovf, nosig;
    logic [11:0] cnt_out;
    logic [7:0]  hi_len, lo_len;
    logic        busy4, valid4, ovf4, nosig4;
    logic [3:0]  cnt_out4;
    logic [7:0]  hi_len4, lo_len4;

    dco_freq_meter #(.CNT_W(12), .GATE_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .dco_in(dco_in), .gate_len(gate_len), .start(start),
        .busy(busy), .valid(valid), .ready(ready), .cnt_out(cnt_out), .ovf(ovf),
        .nosig(nosig), .hi_len(hi_len), .lo_len(lo_len)
    );

    dco_freq_meter #(.CNT_W(4), .GATE_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .dco_in(dco_in), .gate_len(gate_len), .start(start),
        .busy(busy4), .valid(valid4), .ready(ready), .cnt_out(cnt_out4), .ovf(ovf4),
        .nosig(nosig4), .hi_len(hi_len4), .lo_len(lo_len4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int ovf;
        int nosig;
        int hi;
        int lo;
        int cnt4;
        int ovf4;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Square wave with transitions 3 time units after a rising clock edge.
    int hi_t = 11;
    int lo_t = 11;
    bit dco_en = 1'b0;

    initial begin
        forever begin
            if (dco_en) begin
                dco_in = 1'b1;
                #(hi_t * 10);
                dco_in = 1'b0;
                #(lo_t * 10);
            end else begin
                dco_in = 1'b0;
                @(posedge clk);
                #3;
            end
        end
    end

    bit v_prev = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (valid && !v_prev) begin
            if (sb.size() == 0) begin
                check_val("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                check_val("cnt", cnt_out, e.cnt);
                check_val("ovf", ovf, e.ovf);
                check_val("nosig", nosig, e.nosig);
                check_val("hi_len", hi_len, e.hi);
                check_val("lo_len", lo_len, e.lo);
                check_val("busy_at_valid", busy, 0);
                check_val("cnt4", cnt_out4, e.cnt4);
                check_val("ovf4", ovf4, e.ovf4);
                check_val("valid4", valid4, 1);
            end
        end
        v_prev <= valid;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int g);
        gate_len = 16'(g);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        int n;
        n = 0;
        while (!valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!valid) check_val("valid_timeout", 0, 1);
    endtask

    task automatic run_meas(input int g, input exp_t e);
        sb.push_back(e);
        pulse_start(g);
        check_val("busy_rise", busy, 1);
        wait_valid(3 * g + 200);
        wait_cycles(3);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check_val("valid_drop", valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_valid"}, valid, 0);
        check_val({tag, "_cnt"}, cnt_out, 0);
        check_val({tag, "_ovf"}, ovf, 0);
        check_val({tag, "_nosig"}, nosig, 0);
        check_val({tag, "_hi"}, hi_len, 0);
        check_val({tag, "_lo"}, lo_len, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  k;
        bit  stable;
        exp_t e;

        wait_cycles(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        wait_cycles(2);

        // Nominal 11/11 wave
        hi_t = 11; lo_t = 11; dco_en = 1'b1;
        wait_cycles(30);
        run_meas(220, '{10, 0, 0, 11, 11, 10, 0});

        // Result held in HOLD with ready low while start is pulsed
        e = '{10, 0, 0, 11, 11, 10, 0};
        sb.push_back(e);
        pulse_start(220);
        wait_valid(900);
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            gate_len = 16'd50;
            start    = (i % 2 == 0);
            @(negedge clk);
            if (!(valid && !busy && cnt_out == 12'd10 && hi_len == 8'd11 &&
                  lo_len == 8'd11 && !ovf && !nosig)) stable = 1'b0;
        end
        start = 1'b0;
        check_val("hold_stable", stable, 1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check_val("hs_valid_drop", valid, 0);
        check_val("idle_cnt_hold", cnt_out, 10);
        check_val("idle_busy", busy, 0);

        // gate_len of zero is ignored
        pulse_start(0);
        check_val("gate0_busy", busy, 0);
        wait_cycles(5);
        check_val("gate0_busy_late", busy, 0);
        check_val("gate0_valid", valid, 0);

        // Fast 4/4 wave, then saturation of the 4-bit instance
        dco_en = 1'b0;
        wait_cycles(60);
        hi_t = 4; lo_t = 4; dco_en = 1'b1;
        wait_cycles(20);
        run_meas(80, '{10, 0, 0, 4, 4, 10, 0});
        run_meas(200, '{25, 0, 0, 4, 4, 15, 1});

        // No signal: timeout after the gate length in ARM
        dco_en = 1'b0;
        wait_cycles(40);
        e = '{0, 0, 1, 0, 0, 0, 0};
        sb.push_back(e);
        gate_len = 16'd50;
        start    = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) start = 1'b0;
        end while (!valid && k < 300);
        check_val("nosig_latency", k, (k == 52) ? 52 : 51);
        wait_cycles(2);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;

        // Asynchronous reset in the middle of the gate
        hi_t = 11; lo_t = 11; dco_en = 1'b1;
        wait_cycles(30);
        pulse_start(220);
        wait_cycles(130);
        check_val("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(5);
        run_meas(220, '{10, 0, 0, 11, 11, 10, 0});

        wait_cycles(5);
        check_val("sb_left", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
